rr_stream_mux: RTL and testbench

- Parametrised N:1 streaming multiplexer. It is the sequential successor to the combinational 2:1 mux.
- Merges N valid/ready input channels onto one registered output channel.
- Two selection modes:
  - Fixed select: the external `sel` port chooses the channel.
  - Round-robin arbitration: arbitration is packet-locked using `in_last`.
- Sits between multiple producers and a single downstream consumer. Provides the source channel index alongside the data.

---
 rtl/rr_stream_mux.sv | 127 ++++++++++++
 tb/tb_rr_stream_mux.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/rr_stream_mux.sv
// N:1 valid/ready stream multiplexer with a registered output stage.
// The channel is picked either by sel or by packet-locked round-robin.
module rr_stream_mux #(
   parameter int N     = 4,
   parameter int W     = 8,
   parameter int SEL_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mode,
   input  logic [SEL_W-1:0] sel,
   input  logic [N*W-1:0]   in_data,
   input  logic [N-1:0]     in_valid,
   input  logic [N-1:0]     in_last,
   output logic [N-1:0]     in_ready,
   output logic [W-1:0]     out_data,
   output logic             out_valid,
   output logic             out_last,
   output logic [SEL_W-1:0] out_chan,
   input  logic             out_ready
);

   // state  | meaning
   // IDLE   | round-robin search from ptr+1 for the next packet
   // LOCKED | mid-packet, only channel ptr is served until its last beat
   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] LOCKED = 1'b1;

   localparam logic [SEL_W:0]   NUM_CH  = (SEL_W+1)'(N);
   localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N-1);

   logic [0:0]       state;
   logic [SEL_W-1:0] ptr;
   logic [SEL_W-1:0] grant;
   logic             grant_ok;
   logic [SEL_W-1:0] rr_grant;
   logic             rr_found;
   logic             can_load;
   logic             xfer;
   logic [W-1:0]     sel_data;
   logic             sel_last;

   // ptr < N always holds, so ptr+k wraps with at most one subtraction
   always_comb begin
      logic [SEL_W:0]   sum;
      logic [SEL_W-1:0] idx;
      rr_grant = '0;
      rr_found = 1'b0;
      sum      = '0;
      idx      = '0;
      for (int k = 1; k <= N; k++) begin
         sum = {1'b0, ptr} + (SEL_W+1)'(k);
         if (sum >= NUM_CH) sum = sum - NUM_CH;
         idx = sum[SEL_W-1:0];
         for (int i = 0; i < N; i++) begin
            if (!rr_found && idx == SEL_W'(i) && in_valid[i]) begin
               rr_found = 1'b1;
               rr_grant = SEL_W'(i);
            end
         end
      end
   end

   always_comb begin
      grant    = '0;
      grant_ok = 1'b0;
      if (!mode) begin
         grant    = sel;
         grant_ok = ({1'b0, sel} < NUM_CH);
      end else if (state == LOCKED) begin
         grant    = ptr;
         grant_ok = 1'b1;
      end else begin
         grant    = rr_grant;
         grant_ok = rr_found;
      end
   end

   assign can_load = !out_valid || out_ready;

   always_comb begin
      in_ready = '0;
      sel_data = '0;
      sel_last = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (grant == SEL_W'(i)) begin
            in_ready[i] = !rst && can_load && grant_ok;
            sel_data    = in_data[i*W +: W];
            sel_last    = in_last[i];
         end
      end
   end

   assign xfer = |(in_valid & in_ready);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= LAST_CH;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_chan  <= '0;
      end else begin
         if (xfer) begin
            out_data  <= sel_data;
            out_last  <= sel_last;
            out_chan  <= grant;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end

         if (!mode) begin
            state <= IDLE;
         end else if (state == IDLE) begin
            if (xfer) begin
               ptr <= grant;
               if (!sel_last) state <= LOCKED;
            end
         end else if (xfer && sel_last) begin
            state <= IDLE;
         end
      end
   end

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed bench for rr_stream_mux: reset, fixed select, fairness, packet
// lock, backpressure and asynchronous reset mid-packet.
module tb_rr_stream_mux;

   logic        clk;
   logic        rst;
   logic        mode;
   logic [1:0]  sel;
   logic [31:0] in_data;
   logic [3:0]  in_valid;
   logic [3:0]  in_last;
   logic [3:0]  in_ready;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_last;
   logic [1:0]  out_chan;
   logic        out_ready;

   logic [2:0]  in_ready3;
   logic [7:0]  out_data3;
   logic        out_valid3;
   logic        out_last3;
   logic [1:0]  out_chan3;

   int vectors;
   int miscompares;
   int n_in;
   int n_out;

   rr_stream_mux #(.N(4), .W(8), .SEL_W(2)) u_dut (
      .clk(clk), .rst(rst), .mode(mode), .sel(sel),
      .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
      .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
      .out_last(out_last), .out_chan(out_chan), .out_ready(out_ready)
   );

   rr_stream_mux #(.N(3), .W(8), .SEL_W(2)) u_dut3 (
      .clk(clk), .rst(rst), .mode(mode), .sel(sel),
      .in_data(in_data[23:0]), .in_valid(in_valid[2:0]), .in_last(in_last[2:0]),
      .in_ready(in_ready3), .out_data(out_data3), .out_valid(out_valid3),
      .out_last(out_last3), .out_chan(out_chan3), .out_ready(out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (!rst) begin
         if (|(in_valid & in_ready)) n_in = n_in + 1;
         if (out_valid && out_ready) n_out = n_out + 1;
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic test_reset();
      @(negedge clk); @(negedge clk);
      #1;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      vectors++; if (in_ready !== 4'b0000) begin miscompares++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
      vectors++; if (out_data !== 8'h00) begin miscompares++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
      rst = 1'b0;
      #1;
      vectors++; if (in_ready !== 4'b0001) begin miscompares++; $display("FAIL reset_first_ready got=%b exp=0001", in_ready); end
      @(negedge clk);
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL reset_first_valid got=%b exp=1", out_valid); end
      vectors++; if (out_chan !== 2'd0) begin miscompares++; $display("FAIL reset_first_chan got=%0d exp=0", out_chan); end
      vectors++; if (out_data !== 8'h11) begin miscompares++; $display("FAIL reset_first_data got=%h exp=11", out_data); end
      in_valid = 4'b0000;
      @(negedge clk);
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_drain got=%b exp=0", out_valid); end
   endtask

   task automatic test_fixed();
      mode     = 1'b0;
      sel      = 2'd2;
      in_data  = {8'h44, 8'hA5, 8'h22, 8'h11};
      in_valid = 4'b1111;
      #1;
      vectors++; if (in_ready !== 4'b0100) begin miscompares++; $display("FAIL fixed_ready got=%b exp=0100", in_ready); end
      @(negedge clk);
      vectors++; if (out_data !== 8'hA5) begin miscompares++; $display("FAIL fixed_data got=%h exp=a5", out_data); end
      vectors++; if (out_chan !== 2'd2) begin miscompares++; $display("FAIL fixed_chan got=%0d exp=2", out_chan); end
      vectors++; if (out_valid3 !== 1'b1) begin miscompares++; $display("FAIL fixed3_valid got=%b exp=1", out_valid3); end
      sel = 2'd3;
      #1;
      vectors++; if (in_ready3 !== 3'b000) begin miscompares++; $display("FAIL fixed3_oob_ready got=%b exp=000", in_ready3); end
      vectors++; if (in_ready !== 4'b1000) begin miscompares++; $display("FAIL fixed_sel3_ready got=%b exp=1000", in_ready); end
      @(negedge clk);
      vectors++; if (out_valid3 !== 1'b0) begin miscompares++; $display("FAIL fixed3_drain got=%b exp=0", out_valid3); end
      vectors++; if (out_data3 !== 8'hA5) begin miscompares++; $display("FAIL fixed3_hold got=%h exp=a5", out_data3); end
      vectors++; if (out_data !== 8'h44 || out_chan !== 2'd3) begin miscompares++; $display("FAIL fixed_sel3_load got=%h/%0d exp=44/3", out_data, out_chan); end
      in_valid = 4'b0000;
      @(negedge clk);
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL fixed_drain got=%b exp=0", out_valid); end
   endtask

   task automatic test_fairness();
      logic [1:0] exp_chan;
      logic [7:0] exp_data;
      mode     = 1'b1;
      in_data  = {8'h44, 8'h33, 8'h22, 8'h11};
      in_last  = 4'b1111;
      in_valid = 4'b1111;
      rst = 1'b1;
      #1;
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         exp_chan = 2'(k % 4);
         exp_data = 8'(8'h11 * (k % 4 + 1));
         vectors++; if (out_valid !== 1'b1 || out_chan !== exp_chan || out_data !== exp_data)
            begin miscompares++; $display("FAIL rr_beat%0d got=%b/%0d/%h exp=1/%0d/%h", k, out_valid, out_chan, out_data, exp_chan, exp_data); end
      end
      in_valid = 4'b0000;
      @(negedge clk);
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rr_drain got=%b exp=0", out_valid); end
   endtask

   task automatic test_packet_lock();
      in_valid = 4'b0001;
      in_last  = 4'b1111;
      #1;
      vectors++; if (in_ready !== 4'b0001) begin miscompares++; $display("FAIL lock_pre_ready got=%b exp=0001", in_ready); end
      @(negedge clk);
      vectors++; if (out_chan !== 2'd0) begin miscompares++; $display("FAIL lock_pre_chan got=%0d exp=0", out_chan); end
      in_valid = 4'b0111;
      for (int j = 0; j < 3; j++) begin
         in_data = {8'h44, 8'h33, 8'(8'hB0 + j), 8'h11};
         in_last = (j == 2) ? 4'b0111 : 4'b0101;
         #1;
         vectors++; if (in_ready !== 4'b0010) begin miscompares++; $display("FAIL lock_ready%0d got=%b exp=0010", j, in_ready); end
         @(negedge clk);
         vectors++; if (out_chan !== 2'd1 || out_data !== 8'(8'hB0 + j) || out_last !== (j == 2))
            begin miscompares++; $display("FAIL lock_beat%0d got=%0d/%h/%b exp=1/%h/%b", j, out_chan, out_data, out_last, 8'(8'hB0 + j), (j == 2)); end
      end
      #1;
      vectors++; if (in_ready !== 4'b0100) begin miscompares++; $display("FAIL lock_release_ready got=%b exp=0100", in_ready); end
      @(negedge clk);
      vectors++; if (out_chan !== 2'd2 || out_data !== 8'h33) begin miscompares++; $display("FAIL lock_next_chan got=%0d/%h exp=2/33", out_chan, out_data); end
      in_valid = 4'b0000;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int in0, out0;
      in0 = n_in;
      out0 = n_out;
      in_data  = {8'h44, 8'h33, 8'h22, 8'h11};
      in_last  = 4'b1111;
      in_valid = 4'b1000;
      out_ready = 1'b1;
      #1;
      vectors++; if (in_ready !== 4'b1000) begin miscompares++; $display("FAIL bp_first_ready got=%b exp=1000", in_ready); end
      @(negedge clk);
      vectors++; if (out_valid !== 1'b1 || out_data !== 8'h44) begin miscompares++; $display("FAIL bp_first_load got=%b/%h exp=1/44", out_valid, out_data); end
      out_ready = 1'b0;
      in_valid  = 4'b0001;
      for (int j = 0; j < 2; j++) begin
         #1;
         vectors++; if (in_ready !== 4'b0000) begin miscompares++; $display("FAIL bp_stall_ready%0d got=%b exp=0000", j, in_ready); end
         @(negedge clk);
         vectors++; if (out_valid !== 1'b1 || out_data !== 8'h44 || out_chan !== 2'd3)
            begin miscompares++; $display("FAIL bp_hold%0d got=%b/%h/%0d exp=1/44/3", j, out_valid, out_data, out_chan); end
      end
      out_ready = 1'b1;
      #1;
      vectors++; if (in_ready !== 4'b0001) begin miscompares++; $display("FAIL bp_release_ready got=%b exp=0001", in_ready); end
      @(negedge clk);
      vectors++; if (out_valid !== 1'b1 || out_data !== 8'h11 || out_chan !== 2'd0)
         begin miscompares++; $display("FAIL bp_swap got=%b/%h/%0d exp=1/11/0", out_valid, out_data, out_chan); end
      in_valid = 4'b0000;
      @(negedge clk);
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain got=%b exp=0", out_valid); end
      vectors++; if (n_in - in0 !== 2 || n_out - out0 !== 2)
         begin miscompares++; $display("FAIL bp_count got=in%0d/out%0d exp=in2/out2", n_in - in0, n_out - out0); end
   endtask

   task automatic test_async_reset();
      in_data  = {8'h44, 8'hC1, 8'h22, 8'h11};
      in_last  = 4'b0000;
      in_valid = 4'b0100;
      #1;
      vectors++; if (in_ready !== 4'b0100) begin miscompares++; $display("FAIL ar_ready got=%b exp=0100", in_ready); end
      @(negedge clk);
      vectors++; if (out_valid !== 1'b1 || out_chan !== 2'd2 || out_data !== 8'hC1)
         begin miscompares++; $display("FAIL ar_load got=%b/%0d/%h exp=1/2/c1", out_valid, out_chan, out_data); end
      out_ready = 1'b0;
      in_valid  = 4'b1111;
      #1;
      vectors++; if (in_ready !== 4'b0000) begin miscompares++; $display("FAIL ar_stall got=%b exp=0000", in_ready); end
      #1;
      rst = 1'b1;
      #1;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL ar_immediate got=%b exp=0", out_valid); end
      vectors++; if (in_ready !== 4'b0000) begin miscompares++; $display("FAIL ar_ready_in_rst got=%b exp=0000", in_ready); end
      rst       = 1'b0;
      out_ready = 1'b1;
      in_last   = 4'b1111;
      #1;
      vectors++; if (in_ready !== 4'b0001) begin miscompares++; $display("FAIL ar_restart_ready got=%b exp=0001", in_ready); end
      @(negedge clk);
      vectors++; if (out_valid !== 1'b1 || out_chan !== 2'd0 || out_data !== 8'h11)
         begin miscompares++; $display("FAIL ar_restart got=%b/%0d/%h exp=1/0/11", out_valid, out_chan, out_data); end
      in_valid = 4'b0000;
      @(negedge clk);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      n_in        = 0;
      n_out       = 0;
      rst         = 1'b1;
      mode        = 1'b1;
      sel         = 2'd0;
      in_data     = {8'h44, 8'h33, 8'h22, 8'h11};
      in_valid    = 4'b1111;
      in_last     = 4'b1111;
      out_ready   = 1'b1;

      test_reset();
      test_fixed();
      test_fairness();
      test_packet_lock();
      test_back_to_back();
      test_async_reset();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
